// File: rtl/key_gen_par_if.sv
// Handshake and status bundle for key_gen_par.
// Optional feature macro: KEY_GEN_PREFIX_EN adds the key_prefix signal.
interface key_gen_par_if #(
   parameter int KEY_W    = 24,
   parameter int SEARCH_W = 22,
   parameter int NUM_CH   = 4
);
   logic                       start;
   logic                       stop;
   logic [NUM_CH-1:0]          key_ready;
   logic [NUM_CH-1:0]          key_valid;
   logic [NUM_CH*KEY_W-1:0]    key_out;
   logic                       busy;
   logic                       done;
   logic                       exhausted;
   logic [SEARCH_W:0]          keys_issued;
`ifdef KEY_GEN_PREFIX_EN
   logic [KEY_W-SEARCH_W-1:0]  key_prefix;

   // Controller side: issues commands and accepts keys.
   modport master (
      output start, stop, key_ready, key_prefix,
      input  key_valid, key_out, busy, done, exhausted, keys_issued
   );

   // Generator side.
   modport slave (
      input  start, stop, key_ready, key_prefix,
      output key_valid, key_out, busy, done, exhausted, keys_issued
   );
`else
   // Controller side: issues commands and accepts keys.
   modport master (
      output start, stop, key_ready,
      input  key_valid, key_out, busy, done, exhausted, keys_issued
   );

   // Generator side.
   modport slave (
      input  start, stop, key_ready,
      output key_valid, key_out, busy, done, exhausted, keys_issued
   );
`endif
endinterface

// File: rtl/key_gen_par.sv
// Parallel key-space sweeper. NUM_CH channels each walk an interleaved slice
// of the 2^SEARCH_W search space (channel i: i, i+NUM_CH, ...), handing keys
// out over a per-channel valid/ready handshake.
// Optional feature macro: KEY_GEN_PREFIX_EN -- when defined, the upper
// KEY_W-SEARCH_W key bits come from key_prefix sampled on an accepted start;
// otherwise they are zero.
module key_gen_par #(
   parameter int KEY_W    = 24,
   parameter int SEARCH_W = 22,
   parameter int NUM_CH   = 4
) (
   input  logic          clk,
   input  logic          reset,
   key_gen_par_if.slave  bus
);

   localparam int CNT_W = SEARCH_W + 1;
   localparam int PFX_W = KEY_W - SEARCH_W;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RUN       = 2'd1,
      STOPPED   = 2'd2,
      EXHAUSTED = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q [NUM_CH];
   logic [CNT_W-1:0]  issued_q;
   logic [CNT_W-1:0]  xfer_cnt;
   logic [PFX_W-1:0]  prefix_q;
   logic [NUM_CH-1:0] valid;
   logic [NUM_CH-1:0] xfer;
   logic              all_fin;
   logic              start_ok;
   logic              busy_q, done_q, exh_q;

   // A start is only honoured outside a sweep; start+stop in RUN acts as stop.
   assign start_ok = bus.start && (state_q != RUN);

   // Per-channel handshake: a channel is finished once its counter has
   // stepped past the top of the search space (MSB of the wide counter set).
   always_comb begin
      // NOTE: every signal driven here gets a default first so no path can
      // leave it unassigned and infer a latch.
      valid    = '0;
      xfer     = '0;
      all_fin  = 1'b1;
      xfer_cnt = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         valid[i] = (state_q == RUN) && !cnt_q[i][SEARCH_W];
         xfer[i]  = valid[i] && bus.key_ready[i];
         if (!cnt_q[i][SEARCH_W]) all_fin = 1'b0;
         xfer_cnt = xfer_cnt + CNT_W'(xfer[i]);
      end
   end

   // Next-state logic for the sweep controller.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, STOPPED, EXHAUSTED: if (bus.start) state_d = RUN;
         RUN: begin
            if (bus.stop)     state_d = STOPPED;
            else if (all_fin) state_d = EXHAUSTED;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register and registered status flags derived from the next state.
   always_ff @(posedge clk) begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // every register samples pre-edge values regardless of statement order.
      if (reset) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         exh_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d == RUN);
         done_q  <= (state_d == STOPPED) || (state_d == EXHAUSTED);
         exh_q   <= (state_d == EXHAUSTED);
      end
   end

   // Channel counters: load the channel index on start, stride by NUM_CH on
   // each accepted key.
   always_ff @(posedge clk) begin
      // NOTE: the counter array is reset explicitly because key_out must read
      // zero after reset; it is a handful of flops, not a RAM.
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
      end else if (start_ok) begin
         for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= CNT_W'(i);
      end else begin
         for (int i = 0; i < NUM_CH; i++)
            if (xfer[i]) cnt_q[i] <= cnt_q[i] + CNT_W'(NUM_CH);
      end
   end

   // Accepted-key count for the current sweep; includes a transfer that
   // coincides with stop.
   always_ff @(posedge clk) begin
      if (reset)         issued_q <= '0;
      else if (start_ok) issued_q <= '0;
      else               issued_q <= issued_q + xfer_cnt;
   end

`ifdef KEY_GEN_PREFIX_EN
   // Upper key bits are frozen for the whole sweep at the accepted start.
   always_ff @(posedge clk) begin
      if (reset)         prefix_q <= '0;
      else if (start_ok) prefix_q <= bus.key_prefix;
   end
`else
   assign prefix_q = '0;
`endif

   for (genvar g = 0; g < NUM_CH; g++) begin : g_key
      assign bus.key_out[g*KEY_W +: KEY_W] = {prefix_q, cnt_q[g][SEARCH_W-1:0]};
   end

   assign bus.key_valid   = valid;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.exhausted   = exh_q;
   assign bus.keys_issued = issued_q;

endmodule

// File: tb/tb_key_gen_par.sv
// Self-checking bench for key_gen_par (KEY_W=8, SEARCH_W=4, NUM_CH=4).
// Optional feature macro: KEY_GEN_PREFIX_EN (bench drives key_prefix=4'hA).
module tb_key_gen_par;
   localparam int KW    = 8;
   localparam int SW    = 4;
   localparam int NC    = 4;
   localparam int NKEYS = 16;
`ifdef KEY_GEN_PREFIX_EN
   localparam int PFX = 'hA;
`else
   localparam int PFX = 0;
`endif

   typedef enum int {M_IDLE, M_RUN, M_STOP, M_EXH} mstate_t;

   typedef struct {
      logic       st;
      logic       sp;
      logic [3:0] rdy;
      logic       busy;
      logic       done;
      logic       exh;
      logic [4:0] issued;
      logic [3:0] valid;
      logic [3:0] key0;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   key_gen_par_if #(.KEY_W(KW), .SEARCH_W(SW), .NUM_CH(NC)) bus ();

   key_gen_par #(.KEY_W(KW), .SEARCH_W(SW), .NUM_CH(NC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Reference model: per-channel queues of keys still owed, plus sweep status.
   int      exp_q [NC][$];
   mstate_t m_st;
   int      m_issued;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < NC; i++) exp_q[i].delete();
   endtask

   task automatic model_fill();
      model_clear();
      for (int k = 0; k < NKEYS; k++) exp_q[k % NC].push_back(k);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.start = 1'b1;
      bus.stop = 1'b1;
      bus.key_ready = '1;
      step();
      reset = 1'b0;
      bus.start = 1'b0;
      bus.stop = 1'b0;
      bus.key_ready = '0;
      m_st = M_IDLE;
      m_issued = 0;
      model_clear();
   endtask

   // One clock: drive inputs, compare outputs with the model, advance both.
   task automatic cycle(input logic st, input logic sp, input logic [3:0] rdy);
      logic [3:0] m_valid;
      logic       all_empty;
      int         n;
      bus.start = st;
      bus.stop = sp;
      bus.key_ready = rdy;
      m_valid = '0;
      all_empty = 1'b1;
      for (int i = 0; i < NC; i++) begin
         if (exp_q[i].size() > 0) begin
            all_empty = 1'b0;
            if (m_st == M_RUN) m_valid[i] = 1'b1;
         end
      end
      check("busy", 32'(bus.busy), 32'(m_st == M_RUN));
      check("done", 32'(bus.done), 32'(m_st == M_STOP || m_st == M_EXH));
      check("exhausted", 32'(bus.exhausted), 32'(m_st == M_EXH));
      check("keys_issued", 32'(bus.keys_issued), 32'(m_issued));
      check("key_valid", 32'(bus.key_valid), 32'(m_valid));
      for (int i = 0; i < NC; i++)
         if (m_valid[i])
            check($sformatf("key_out_ch%0d", i), 32'(bus.key_out[i*KW +: KW]),
                  32'((PFX << SW) | exp_q[i][0]));
      if (m_st == M_RUN) begin
         n = 0;
         for (int i = 0; i < NC; i++)
            if (m_valid[i] && rdy[i]) begin
               void'(exp_q[i].pop_front());
               n++;
            end
         m_issued += n;
         if (sp)             m_st = M_STOP;
         else if (all_empty) m_st = M_EXH;
      end else if (st) begin
         model_fill();
         m_issued = 0;
         m_st = M_RUN;
      end
      step();
      bus.start = 1'b0;
      bus.stop = 1'b0;
   endtask

   task automatic run_until_end(input int budget, input logic [3:0] rdy);
      for (int c = 0; c < budget && m_st == M_RUN; c++) cycle(1'b0, 1'b0, rdy);
      check("sweep_end_timeout", 32'(m_st != M_RUN), 32'd1);
   endtask

   vec_t tbl [8];

   initial begin
      reset = 1'b1;
      bus.start = 1'b0;
      bus.stop = 1'b0;
      bus.key_ready = '0;
`ifdef KEY_GEN_PREFIX_EN
      bus.key_prefix = 4'(PFX);
`endif
      m_st = M_IDLE;
      m_issued = 0;
      step();
      step();
      reset = 1'b0;

      // Reset state.
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_exhausted", 32'(bus.exhausted), 32'd0);
      check("rst_issued", 32'(bus.keys_issued), 32'd0);
      check("rst_valid", 32'(bus.key_valid), 32'd0);
      check("rst_key_out", bus.key_out, 32'd0);

      // Table: start, partial accept, stop after 6 keys, restart, start in RUN.
      tbl[0] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 5'd0, 4'h0, 4'h0};
      tbl[1] = '{1'b0, 1'b0, 4'h3, 1'b1, 1'b0, 1'b0, 5'd0, 4'hF, 4'h0};
      tbl[2] = '{1'b0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 5'd2, 4'hF, 4'h4};
      tbl[3] = '{1'b0, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 5'd6, 4'h0, 4'h8};
      tbl[4] = '{1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 5'd6, 4'h0, 4'h8};
      tbl[5] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 5'd0, 4'hF, 4'h0};
      tbl[6] = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 5'd0, 4'hF, 4'h0};
      tbl[7] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 5'd0, 4'hF, 4'h0};
      for (int v = 0; v < 8; v++) begin
         bus.start = tbl[v].st;
         bus.stop = tbl[v].sp;
         bus.key_ready = tbl[v].rdy;
         check($sformatf("tbl%0d_busy", v), 32'(bus.busy), 32'(tbl[v].busy));
         check($sformatf("tbl%0d_done", v), 32'(bus.done), 32'(tbl[v].done));
         check($sformatf("tbl%0d_exh", v), 32'(bus.exhausted), 32'(tbl[v].exh));
         check($sformatf("tbl%0d_issued", v), 32'(bus.keys_issued), 32'(tbl[v].issued));
         check($sformatf("tbl%0d_valid", v), 32'(bus.key_valid), 32'(tbl[v].valid));
         check($sformatf("tbl%0d_key0", v), 32'(bus.key_out[3:0]), 32'(tbl[v].key0));
         step();
      end

      // Full sweep with every channel always ready.
      do_reset();
      cycle(1'b1, 1'b0, 4'hF);
      run_until_end(20, 4'hF);
      cycle(1'b0, 1'b0, 4'hF);
      check("full_exhausted", 32'(bus.exhausted), 32'd1);
      check("full_issued", 32'(bus.keys_issued), 32'(NKEYS));

      // Channel 1 back-pressured for 5 cycles; its key must hold.
      do_reset();
      cycle(1'b1, 1'b0, 4'hF);
      for (int c = 0; c < 5; c++) begin
         check("bp_ch1_valid", 32'(bus.key_valid[1]), 32'd1);
         check("bp_ch1_key", 32'(bus.key_out[KW +: KW]), 32'((PFX << SW) | 1));
         cycle(1'b0, 1'b0, 4'b1101);
      end
      run_until_end(20, 4'hF);
      cycle(1'b0, 1'b0, 4'h0);
      check("bp_exhausted", 32'(bus.exhausted), 32'd1);
      check("bp_issued", 32'(bus.keys_issued), 32'(NKEYS));

      // Stop coincident with the 16th transfer.
      do_reset();
      cycle(1'b1, 1'b0, 4'hF);
      cycle(1'b0, 1'b0, 4'hF);
      cycle(1'b0, 1'b0, 4'hF);
      cycle(1'b0, 1'b0, 4'hF);
      cycle(1'b0, 1'b1, 4'hF);
      check("stop16_done", 32'(bus.done), 32'd1);
      check("stop16_exh", 32'(bus.exhausted), 32'd0);
      check("stop16_issued", 32'(bus.keys_issued), 32'(NKEYS));
      check("stop16_valid", 32'(bus.key_valid), 32'd0);

      // Reset mid-RUN dominates start/stop; start during RUN is ignored.
      do_reset();
      cycle(1'b1, 1'b0, 4'h5);
      cycle(1'b1, 1'b0, 4'hA);
      cycle(1'b0, 1'b0, 4'h0);
      do_reset();
      check("midrst_busy", 32'(bus.busy), 32'd0);
      check("midrst_done", 32'(bus.done), 32'd0);
      check("midrst_exh", 32'(bus.exhausted), 32'd0);
      check("midrst_issued", 32'(bus.keys_issued), 32'd0);
      check("midrst_valid", 32'(bus.key_valid), 32'd0);
      check("midrst_key_out", bus.key_out, 32'd0);
      cycle(1'b0, 1'b1, 4'hF);

      // Randomized sweeps with random back-pressure, stray starts and stops.
      for (int s = 0; s < 12; s++) begin
         cycle(1'b1, 1'($urandom_range(0, 3) == 0), 4'($urandom));
         for (int c = 0; c < 120 && m_st == M_RUN; c++)
            cycle(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 39) == 0),
                  4'($urandom));
         check("rand_sweep_end", 32'(m_st != M_RUN), 32'd1);
         cycle(1'b0, 1'($urandom_range(0, 1)), 4'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/key_gen_par.md
KEY_GEN_PAR -- requirements
Module: key_gen_par

Interface
REQ-001 Parameter KEY_W, default 24, full key width in bits.
REQ-002 Parameter SEARCH_W, default 22, searched low-order key bits; SHALL satisfy SEARCH_W < KEY_W.
REQ-003 Parameter NUM_CH, default 4, number of key channels; SHALL be a power of 2 in 1..16 and SHALL NOT exceed 2^SEARCH_W.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse; begins a new key-space sweep.
REQ-007 stop  input  1  one-cycle pulse; key found, abort sweep.
REQ-008 key_ready  input  NUM_CH  per-channel consumer ready.
REQ-009 key_valid  output  NUM_CH  per-channel key presented.
REQ-010 key_out  output  NUM_CH*KEY_W  per-channel key; channel i occupies bits [i*KEY_W +: KEY_W].
REQ-011 busy  output  1  sweep in progress.
REQ-012 done  output  1  sweep ended (stopped or exhausted).
REQ-013 exhausted  output  1  every key in the space was accepted.
REQ-014 keys_issued  output  SEARCH_W+1  count of accepted keys in the current sweep.

Function
REQ-015 Top FSM states SHALL be IDLE, RUN, STOPPED and EXHAUSTED.
REQ-016 In IDLE, STOPPED or EXHAUSTED, start SHALL enter RUN on the next cycle, load channel i counter with i, and clear keys_issued.
REQ-017 start in RUN SHALL be ignored.
REQ-018 Channel i SHALL cover exactly keys i, i+NUM_CH, i+2*NUM_CH, ..., up to 2^SEARCH_W-1 (interleaved partition, no gaps, no overlap).
REQ-019 A key transfer SHALL occur on a cycle where key_valid[i] and key_ready[i] are both high.
REQ-020 While key_valid[i] is high without a transfer, key_out for channel i SHALL hold stable.
REQ-021 After a transfer, the channel counter SHALL advance by NUM_CH.
REQ-022 After a non-final transfer, the channel SHALL present the next key in the following cycle; latency is 1 and key_valid stays high with back-to-back ready.
REQ-023 key_valid[i] SHALL be high on the first RUN cycle.
REQ-024 Key arithmetic: counter width SHALL be SEARCH_W+1 so the final increment does not wrap. A channel SHALL be finished when its counter exceeds 2^SEARCH_W-1, and then drives key_valid[i]=0.
REQ-025 key_out[i] SHALL be {upper bits, counter[SEARCH_W-1:0]}; upper KEY_W-SEARCH_W bits are zero unless REQ-036 applies.
REQ-026 keys_issued SHALL increment by the number of transfers in each cycle (0..NUM_CH), counting every transfer including one coincident with stop.
REQ-027 RUN to EXHAUSTED SHALL occur the cycle after all channels are finished; keys_issued then equals 2^SEARCH_W.
REQ-028 stop in RUN SHALL enter STOPPED next cycle; all key_valid SHALL be low from that cycle on.
REQ-029 stop coincident with the final transfer SHALL yield STOPPED, not EXHAUSTED.
REQ-030 stop outside RUN SHALL be ignored.
REQ-031 start and stop in the same cycle SHALL be treated as start in IDLE/STOPPED/EXHAUSTED, and as stop in RUN.
REQ-032 Outputs: busy=(RUN), done=(STOPPED or EXHAUSTED), exhausted=(EXHAUSTED), all registered.

Reset
REQ-033 reset SHALL dominate start and stop.
REQ-034 On reset: state=IDLE; all counters=0; key_valid=0; key_out=0; busy=0; done=0; exhausted=0; keys_issued=0.
REQ-035 Reset asserted mid-RUN SHALL abort within one cycle; no transfer is counted in the reset cycle.

Configuration
REQ-036 Macro KEY_GEN_PREFIX_EN defined: add input key_prefix, KEY_W-SEARCH_W wide, sampled on accepted start; key_out upper bits SHALL equal the sampled prefix for the whole sweep.
REQ-037 Macro KEY_GEN_PREFIX_EN undefined: no key_prefix port; upper bits SHALL be zero.

Verification (KEY_W=8, SEARCH_W=4, NUM_CH=4 unless noted)
REQ-038 reset, start, all key_ready=1 -> channel 0 emits 0,4,8,12; channel 3 emits 3,7,11,15; EXHAUSTED after 4 transfers per channel; keys_issued=16, exhausted=1.
REQ-039 start, key_ready[1] held 0 for 5 cycles -> key_out ch1 stays 1, key_valid[1]=1 throughout; other channels proceed; sweep still ends exhausted with keys_issued=16.
REQ-040 start, stop after 6 total transfers -> done=1, exhausted=0, keys_issued=6, all key_valid=0 next cycle; a second start restarts ch0 at key 0.
REQ-041 stop in the same cycle as the 16th transfer -> STOPPED, exhausted=0, keys_issued=16.
REQ-042 reset pulsed mid-RUN -> next cycle all outputs zero, state IDLE; start pulses during RUN have no effect.
REQ-043 KEY_GEN_PREFIX_EN, key_prefix=4'hA at start, NUM_CH=1 -> key_out sequence 8'hA0..8'hAF in order.
